// File: rtl/fifo_spi_tx.sv
// ---------------------------------------------------------------------------
// fifo_spi_tx
//
// Drains bytes from the read port of the async FIFO and shifts them out as an
// SPI master (mode 0, MSB first). cs_n stays asserted across back-to-back
// bytes while the FIFO still holds data and enable is high, forming bursts.
//
// Frame sequence:
//   IDLE -> FETCH -> CAPTURE -> CS_SETUP -> SHIFT -> GAP -> CS_HOLD -> IDLE
//   A burst continues GAP -> FETCH -> CAPTURE -> SHIFT, skipping CS_SETUP.
//
// Parameters:
//   DATA_WIDTH  FIFO word width and SPI frame length in bits (>= 2)
//   CLK_DIV     clk cycles per SCLK half-period (1..255)
//   CNT_W       width of byte_count
//
// Ports:
//   clk         system clock, also the FIFO read clock
//   rst         asynchronous active-high reset
//   enable      permits new transfers (sampled in IDLE and GAP only)
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid one cycle after fifo_rd_en
//   fifo_rd_en  one-cycle FIFO read strobe
//   sclk        SPI clock, idles low
//   mosi        SPI data out
//   miso        SPI data in
//   cs_n        SPI chip select, active low
//   busy        high in every state except IDLE
//   rx_data     last received byte
//   rx_valid    one-cycle pulse when rx_data updates
//   byte_count  number of bytes fully transmitted (wraps)
//
// Build option:
//   SPI_RX_CAPTURE_EN  when defined, miso is shifted in on every sclk rising
//                      edge and presented on rx_data/rx_valid at the end of
//                      each byte. When undefined, miso is ignored and
//                      rx_data/rx_valid are tied to zero.
// ---------------------------------------------------------------------------
module fifo_spi_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic [CNT_W-1:0]      byte_count
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);
    localparam logic [7:0]       DIV_RELOAD = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        CS_SETUP,
        SHIFT,
        GAP,
        CS_HOLD
    } state_t;

    state_t                  state;
    logic [7:0]              div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   tx_shift;

    logic div_done;
    logic byte_done;

    assign div_done  = (div_cnt == 8'd0);
    // Final high phase of the last bit has expired: sclk falls and the byte
    // is complete on this edge.
    assign byte_done = (state == SHIFT) && div_done && sclk && (bit_cnt == BIT_LAST);

    // NOTE: state and registered outputs are updated with non-blocking
    // assignments so every branch sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= DIV_RELOAD;
            bit_cnt    <= '0;
            tx_shift   <= '0;
            fifo_rd_en <= 1'b0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= 1'b1;
            busy       <= 1'b0;
            byte_count <= '0;
        end else begin
            // NOTE: strobe defaults low each cycle; only the IDLE/GAP -> FETCH
            // transition raises it, which guarantees a single-cycle pulse.
            fifo_rd_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable && !fifo_empty) begin
                        state      <= FETCH;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                        div_cnt    <= DIV_RELOAD;
                    end
                end

                FETCH: begin
                    state   <= CAPTURE;
                    div_cnt <= DIV_RELOAD;
                end

                CAPTURE: begin
                    // fifo_dout is valid now, one cycle after the read strobe.
                    tx_shift <= fifo_dout;
                    mosi     <= fifo_dout[DATA_WIDTH-1];
                    bit_cnt  <= '0;
                    div_cnt  <= DIV_RELOAD;
                    if (cs_n) begin
                        cs_n  <= 1'b0;
                        state <= CS_SETUP;
                    end else begin
                        state <= SHIFT;
                    end
                end

                CS_SETUP: begin
                    if (div_done) begin
                        state   <= SHIFT;
                        div_cnt <= DIV_RELOAD;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end

                SHIFT: begin
                    if (!div_done) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        div_cnt <= DIV_RELOAD;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                byte_count <= byte_count + 1'b1;
                                state      <= GAP;
                            end else begin
                                // Next bit appears on mosi together with the
                                // falling sclk edge, i.e. while sclk is low.
                                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                                mosi     <= tx_shift[DATA_WIDTH-2];
                                bit_cnt  <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end

                GAP: begin
                    div_cnt <= DIV_RELOAD;
                    if (enable && !fifo_empty) begin
                        state      <= FETCH;
                        fifo_rd_en <= 1'b1;
                    end else begin
                        state <= CS_HOLD;
                    end
                end

                CS_HOLD: begin
                    if (div_done) begin
                        cs_n    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                        div_cnt <= DIV_RELOAD;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_RX_CAPTURE_EN
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  sclk_rise;

    // sclk goes 0 -> 1 on this edge; mosi/miso have been stable for a full
    // low phase.
    assign sclk_rise = (state == SHIFT) && div_done && !sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (sclk_rise) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
            end
            if (byte_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_miso;
    logic unused_byte_done;

    assign unused_miso      = miso;
    assign unused_byte_done = byte_done;
    assign rx_data          = '0;
    assign rx_valid         = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_spi_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_spi_tx
//
// Directed bench for fifo_spi_tx with CLK_DIV=2, DATA_WIDTH=8. A small FIFO
// model answers fifo_rd_en with data one cycle later. Outputs are sampled on
// the falling clk edge; inputs are driven there as well.
// ---------------------------------------------------------------------------
module tb_fifo_spi_tx;

    localparam int DW = 8;
    localparam int CD = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd_en;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic          cs_n;
    logic          busy;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [CW-1:0] byte_count;
    logic          loop_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign miso = loop_en & mosi;

    fifo_spi_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .cs_n       (cs_n),
        .busy       (busy),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .byte_count (byte_count)
    );

    // FIFO model: mem/wr_ptr written by the stimulus, rd_ptr by the read port.
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_on_empty = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_empty) begin
                rd_on_empty <= rd_on_empty + 1;
            end else begin
                fifo_dout <= mem[rd_ptr % 64];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    // mosi and cs_n may only move while sclk is low.
    int   glitch_cnt = 0;
    logic mon_mosi   = 1'b0;
    logic mon_cs     = 1'b1;

    always @(negedge clk) begin
        if (sclk && ((mosi !== mon_mosi) || (cs_n !== mon_cs)))
            glitch_cnt <= glitch_cnt + 1;
        mon_mosi <= mosi;
        mon_cs   <= cs_n;
    end

    task automatic push_bytes(input int n, input logic [23:0] v);
        for (int i = 0; i < n; i++)
            mem[(wr_ptr + i) % 64] = v[8*(n-1-i) +: 8];
        wr_ptr = wr_ptr + n;
    endtask

    // Frame observer results.
    int         o_cyc, o_rd, o_t_rd, o_t_csf, o_t_csr, o_t_fall;
    int         o_cs_falls, o_cs_rises, o_rises, o_hmin, o_hmax, o_gmax;
    logic [31:0] o_bits;
    logic [7:0] o_rx [$];
    logic       o_done;

    // Watch one activity period (busy rises then falls). drop_at>0 clears
    // enable on that sclk rising edge.
    task automatic observe(input int max_cycles, input int drop_at);
        logic p_cs, p_sclk, seen;
        int   hw, lw;
        o_cyc = 0; o_rd = 0; o_t_rd = -1; o_t_csf = 0; o_t_csr = 0; o_t_fall = 0;
        o_cs_falls = 0; o_cs_rises = 0; o_rises = 0; o_hmin = 999; o_hmax = 0;
        o_gmax = 0; o_bits = '0; o_rx.delete(); o_done = 1'b0;
        p_cs = cs_n; p_sclk = sclk; seen = 1'b0; hw = 0; lw = 0;
        while (!o_done && o_cyc < max_cycles) begin
            @(negedge clk);
            o_cyc++;
            if (fifo_rd_en) begin
                o_rd++;
                if (o_t_rd < 0) o_t_rd = o_cyc;
            end
            if (!cs_n && p_cs) begin o_cs_falls++; o_t_csf = o_cyc; end
            if (cs_n && !p_cs) begin o_cs_rises++; o_t_csr = o_cyc; end
            if (sclk && !p_sclk) begin
                o_rises++;
                o_bits = {o_bits[30:0], mosi};
                if (o_rises > 1 && lw > o_gmax) o_gmax = lw;
                hw = 0;
                if (o_rises == drop_at) enable = 1'b0;
            end
            if (!sclk && p_sclk) begin
                o_t_fall = o_cyc;
                if (hw < o_hmin) o_hmin = hw;
                if (hw > o_hmax) o_hmax = hw;
                lw = 0;
            end
            if (sclk) hw++; else lw++;
            if (rx_valid) o_rx.push_back(rx_data);
            if (busy) seen = 1'b1;
            else if (seen) o_done = 1'b1;
            p_cs = cs_n; p_sclk = sclk;
        end
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL observe_timeout: busy=%0b after %0d cycles, required 0", busy, max_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; loop_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cs_n, sclk, mosi, fifo_rd_en, busy, rx_valid} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: {cs_n,sclk,mosi,rd_en,busy,rx_valid}=%b required 100000",
                     {cs_n, sclk, mosi, fifo_rd_en, busy, rx_valid});
        end
        checks++;
        if (byte_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_byte_count: got %0d required 0", byte_count);
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data: got %h required 00", rx_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_empty();
        int bad = 0;
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_rd_en || !cs_n || sclk || busy) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL empty_idle: %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_single();
        push_bytes(1, 24'h0000A5);
        observe(300, 0);
        checks++;
        if (o_rd !== 1) begin errors++; $display("FAIL single_rd_pulses: got %0d required 1", o_rd); end
        // FETCH at t, CAPTURE at t+1, CS_SETUP (cs_n low) at t+2.
        checks++;
        if (o_t_csf - o_t_rd !== 2) begin
            errors++; $display("FAIL single_cs_fall: got %0d cycles after rd_en required 2", o_t_csf - o_t_rd);
        end
        checks++;
        if (o_bits[7:0] !== 8'hA5) begin errors++; $display("FAIL single_mosi: got %h required a5", o_bits[7:0]); end
        checks++;
        if (o_rises !== 8) begin errors++; $display("FAIL single_sclk_pulses: got %0d required 8", o_rises); end
        checks++;
        if (o_hmin !== CD || o_hmax !== CD) begin
            errors++; $display("FAIL single_high_width: min %0d max %0d required %0d", o_hmin, o_hmax, CD);
        end
        // GAP (1 cycle) + CS_HOLD (CLK_DIV cycles) after the final fall.
        checks++;
        if (o_t_csr - o_t_fall !== CD + 1) begin
            errors++; $display("FAIL single_cs_rise: got %0d required %0d", o_t_csr - o_t_fall, CD + 1);
        end
        checks++;
        if (byte_count !== 16'd1) begin errors++; $display("FAIL single_byte_count: got %0d required 1", byte_count); end
        checks++;
        if (busy !== 1'b0 || cs_n !== 1'b1) begin
            errors++; $display("FAIL single_idle_after: busy=%0b cs_n=%0b required 0/1", busy, cs_n);
        end
    endtask

    task automatic test_burst();
        logic [CW-1:0] bc0 = byte_count;
        push_bytes(3, 24'h3CF081);
        observe(600, 0);
        checks++;
        if (o_cs_falls !== 1 || o_cs_rises !== 1) begin
            errors++; $display("FAIL burst_cs: falls %0d rises %0d required 1/1", o_cs_falls, o_cs_rises);
        end
        checks++;
        if (o_rises !== 24) begin errors++; $display("FAIL burst_sclk_pulses: got %0d required 24", o_rises); end
        checks++;
        if (o_rd !== 3) begin errors++; $display("FAIL burst_rd_pulses: got %0d required 3", o_rd); end
        checks++;
        if (o_bits[23:0] !== 24'h3CF081) begin
            errors++; $display("FAIL burst_mosi: got %h required 3cf081", o_bits[23:0]);
        end
        // GAP + FETCH + CAPTURE + CLK_DIV low cycles between bytes.
        checks++;
        if (o_gmax !== CD + 3) begin errors++; $display("FAIL burst_gap: got %0d required %0d", o_gmax, CD + 3); end
        checks++;
        if (byte_count !== CW'(bc0 + 3)) begin
            errors++; $display("FAIL burst_byte_count: got %0d required %0d", byte_count, bc0 + 3);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] r0, r1;
        loop_en = 1'b1;
        push_bytes(2, 24'h005AC3);
        observe(500, 0);
        r0 = (o_rx.size() > 0) ? o_rx[0] : 8'hxx;
        r1 = (o_rx.size() > 1) ? o_rx[1] : 8'hxx;
        checks++;
        if (o_bits[15:0] !== 16'h5AC3) begin
            errors++; $display("FAIL loop_mosi: got %h required 5ac3", o_bits[15:0]);
        end
`ifdef SPI_RX_CAPTURE_EN
        checks++;
        if (o_rx.size() !== 2) begin errors++; $display("FAIL loop_rx_count: got %0d required 2", o_rx.size()); end
        checks++;
        if (r0 !== 8'h5A) begin errors++; $display("FAIL loop_rx0: got %h required 5a", r0); end
        checks++;
        if (r1 !== 8'hC3) begin errors++; $display("FAIL loop_rx1: got %h required c3", r1); end
`else
        checks++;
        if (o_rx.size() !== 0) begin
            errors++; $display("FAIL loop_rx_count: got %0d first %h required 0", o_rx.size(), r0);
        end
        checks++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL loop_rx_data: got %h required 00", rx_data); end
        if (r1 === 8'h00) loop_en = 1'b0;
`endif
        loop_en = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [CW-1:0] bc0 = byte_count;
        push_bytes(2, 24'h009611);
        observe(500, 4);
        checks++;
        if (o_bits[7:0] !== 8'h96 || o_rises !== 8) begin
            errors++; $display("FAIL drop_mosi: got %h after %0d pulses required 96 after 8", o_bits[7:0], o_rises);
        end
        checks++;
        if (o_rd !== 1) begin errors++; $display("FAIL drop_rd_pulses: got %0d required 1", o_rd); end
        checks++;
        if (wr_ptr - rd_ptr !== 1) begin
            errors++; $display("FAIL drop_fifo_level: got %0d required 1", wr_ptr - rd_ptr);
        end
        checks++;
        if (byte_count !== CW'(bc0 + 1)) begin
            errors++; $display("FAIL drop_byte_count: got %0d required %0d", byte_count, bc0 + 1);
        end
        checks++;
        if (cs_n !== 1'b1) begin errors++; $display("FAIL drop_cs_release: cs_n=%0b required 1", cs_n); end
        enable = 1'b1;
        observe(300, 0);
        checks++;
        if (o_bits[7:0] !== 8'h11) begin errors++; $display("FAIL drop_resume: got %h required 11", o_bits[7:0]); end
    endtask

    task automatic test_reset_mid_byte();
        int   r = 0;
        logic p;
        push_bytes(2, 24'h00FF42);
        p = sclk;
        for (int i = 0; i < 200 && r < 6; i++) begin
            @(negedge clk);
            if (sclk && !p) r++;
            p = sclk;
        end
        checks++;
        if (r !== 6) begin errors++; $display("FAIL rstmid_reach_bit5: pulses %0d required 6", r); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cs_n, sclk, mosi, busy} !== 4'b1000) begin
            errors++; $display("FAIL rstmid_outputs: {cs_n,sclk,mosi,busy}=%b required 1000", {cs_n, sclk, mosi, busy});
        end
        checks++;
        if (byte_count !== 16'd0) begin errors++; $display("FAIL rstmid_byte_count: got %0d required 0", byte_count); end
        @(negedge clk);
        rst = 1'b0;
        observe(300, 0);
        checks++;
        if (o_bits[7:0] !== 8'h42 || o_rd !== 1) begin
            errors++; $display("FAIL rstmid_next_byte: got %h rd %0d required 42 rd 1", o_bits[7:0], o_rd);
        end
        checks++;
        if (byte_count !== 16'd1) begin errors++; $display("FAIL rstmid_count_after: got %0d required 1", byte_count); end
    endtask

    task automatic test_signal_quality();
        checks++;
        if (glitch_cnt !== 0) begin
            errors++; $display("FAIL quality_sclk_high_change: %0d events required 0", glitch_cnt);
        end
        checks++;
        if (rd_on_empty !== 0) begin
            errors++; $display("FAIL quality_rd_on_empty: %0d strobes required 0", rd_on_empty);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_burst();
        test_loopback();
        test_enable_drop();
        test_reset_mid_byte();
        test_signal_quality();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
